// File: rtl/imm_gen_pipe_pkg.sv
// Shared decode constants: immediate format selects and the default datapath width.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_Z   = 3'b101;
  localparam logic [2:0] IMM_SH  = 3'b110;
  localparam logic [2:0] IMM_RSV = 3'b111;

endpackage

// File: rtl/imm_gen_pipe_extend.sv
// Combinational immediate extraction: builds a 32-bit field, then sign- or zero-extends it to XLEN.
module imm_extend_core
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] immext,
  output logic            imm_err
);

  logic [31:0] imm32;
  logic        sext;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32   = '0;
    sext    = 1'b1;
    imm_err = 1'b0;
    case (immsrc)
      IMM_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:  imm32 = {instr[31:12], 12'b0};
      IMM_Z: begin
        imm32 = {27'b0, instr[19:15]};
        sext  = 1'b0;
      end
      IMM_SH: begin
        // RV64 shift amounts carry a sixth bit in instr[25].
        imm32 = (XLEN == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
        sext  = 1'b0;
      end
      default: begin
        imm32   = '0;
        imm_err = 1'b1;
      end
    endcase
    immext = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with PC-relative target, behind a 2-entry skid buffer.
module imm_gen_pipe
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      immsrc,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic [XLEN-1:0] tgt,
  output logic            imm_err,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] new_imm;
  logic [XLEN-1:0] new_tgt;
  logic            new_err;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_tgt;
  logic            skid_err;

  imm_extend_core #(.XLEN(XLEN)) u_extend (
    .instr   (instr),
    .immsrc  (immsrc),
    .immext  (new_imm),
    .imm_err (new_err)
  );

  assign new_tgt   = pc + new_imm;
  assign dbg_state = state;

  // Handshake: an input transfers on in_valid && in_ready, an output on out_valid && out_ready.
  // in_ready and out_valid are registered; the main entry drives outputs and holds while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      immext    <= '0;
      tgt       <= '0;
      imm_err   <= 1'b0;
      skid_imm  <= '0;
      skid_tgt  <= '0;
      skid_err  <= 1'b0;
    end else if (flush) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_valid) begin
            immext    <= new_imm;
            tgt       <= new_tgt;
            imm_err   <= new_err;
            out_valid <= 1'b1;
            state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (out_ready && in_valid) begin
            immext  <= new_imm;
            tgt     <= new_tgt;
            imm_err <= new_err;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end else if (in_valid) begin
            skid_imm <= new_imm;
            skid_tgt <= new_tgt;
            skid_err <= new_err;
            in_ready <= 1'b0;
            state    <= S_FULL;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            immext   <= skid_imm;
            tgt      <= skid_tgt;
            imm_err  <= skid_err;
            in_ready <= 1'b1;
            state    <= S_ONE;
          end
        end
        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus, scoreboarded against a format model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [2:0]  immsrc;
  logic [63:0] pc;

  logic        in_ready32, out_valid32, err32;
  logic [31:0] immext32, tgt32;
  logic [1:0]  st32;
  logic        in_ready64, out_valid64, err64;
  logic [63:0] immext64, tgt64;
  logic [1:0]  st64;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;
  bit started  = 1'b0;

  logic [128:0] exp_q32[$];
  logic [128:0] exp_q64[$];
  logic [128:0] mon_e;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .pc(pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
    .immext(immext32), .tgt(tgt32), .imm_err(err32), .dbg_state(st32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .pc(pc), .out_valid(out_valid64), .out_ready(out_ready),
    .immext(immext64), .tgt(tgt64), .imm_err(err64), .dbg_state(st64)
  );

  // Reference: immediate value as a plain integer, then wrapped to the datapath width.
  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
    longint v;
    v = 0;
    case (src)
      3'd0: begin v = ins[31:20]; if (ins[31]) v -= 4096; end
      3'd1: begin v = {ins[31:25], ins[11:7]}; if (ins[31]) v -= 4096; end
      3'd2: begin v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; if (ins[31]) v -= 8192; end
      3'd3: begin v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; if (ins[31]) v -= (longint'(1) << 21); end
      3'd4: begin v = longint'(ins[31:12]) * 4096; if (ins[31]) v -= (longint'(1) << 32); end
      3'd5: v = ins[19:15];
      3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    if (xlen == 64) return 64'(v);
    return {32'b0, v[31:0]};
  endfunction

  function automatic logic [128:0] model_entry(input logic [31:0] ins, input logic [2:0] src,
                                                input logic [63:0] pcv, input int xlen);
    logic [63:0] imm, t;
    imm = model_imm(ins, src, xlen);
    t   = pcv + imm;
    if (xlen == 32) t = {32'b0, t[31:0]};
    return {src == 3'b111, t, imm};
  endfunction

  // Scoreboard monitor: inputs only change at posedge+1, so negedge sees what the next edge will use.
  always @(negedge clk) begin
    if (started) begin
      if (!rst_n) begin
        exp_q32.delete();
        exp_q64.delete();
      end else begin
        n_checks++;
        if (out_valid32 !== (exp_q32.size() != 0) || in_ready32 !== (exp_q32.size() < 2)) begin
          n_errors++;
          $display("FAIL occupancy32: out_valid=%b in_ready=%b, expected %0d entries held", out_valid32, in_ready32, exp_q32.size());
        end
        n_checks++;
        if (out_valid64 !== (exp_q64.size() != 0) || in_ready64 !== (exp_q64.size() < 2)) begin
          n_errors++;
          $display("FAIL occupancy64: out_valid=%b in_ready=%b, expected %0d entries held", out_valid64, in_ready64, exp_q64.size());
        end
        if (out_valid32 === 1'b1 && out_ready && exp_q32.size() != 0) begin
          mon_e = exp_q32.pop_front();
          n_pops++;
          n_checks++;
          if (immext32 !== mon_e[31:0] || tgt32 !== mon_e[95:64] || err32 !== mon_e[128]) begin
            n_errors++;
            $display("FAIL data32: got imm=%h tgt=%h err=%b, expected imm=%h tgt=%h err=%b",
                     immext32, tgt32, err32, mon_e[31:0], mon_e[95:64], mon_e[128]);
          end
        end
        if (out_valid64 === 1'b1 && out_ready && exp_q64.size() != 0) begin
          mon_e = exp_q64.pop_front();
          n_checks++;
          if (immext64 !== mon_e[63:0] || tgt64 !== mon_e[127:64] || err64 !== mon_e[128]) begin
            n_errors++;
            $display("FAIL data64: got imm=%h tgt=%h err=%b, expected imm=%h tgt=%h err=%b",
                     immext64, tgt64, err64, mon_e[63:0], mon_e[127:64], mon_e[128]);
          end
        end
        if (flush) begin
          exp_q32.delete();
          exp_q64.delete();
        end else if (in_valid) begin
          if (in_ready32 === 1'b1) exp_q32.push_back(model_entry(instr, immsrc, pc, 32));
          if (in_ready64 === 1'b1) exp_q64.push_back(model_entry(instr, immsrc, pc, 64));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (exp_q32.size() == 0 && exp_q64.size() == 0) break;
      tick();
    end
    n_checks++;
    if (exp_q32.size() != 0 || exp_q64.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d/%0d entries still pending, expected 0", exp_q32.size(), exp_q64.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; instr = $urandom; immsrc = 3'd0; pc = {$urandom, $urandom};
    @(posedge clk);
    started = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || immext32 !== 32'h0 || tgt32 !== 32'h0 || err32 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset32: out_valid=%b in_ready=%b imm=%h tgt=%h err=%b, expected 0 1 0 0 0",
               out_valid32, in_ready32, immext32, tgt32, err32);
    end
    n_checks++;
    if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || immext64 !== 64'h0 || tgt64 !== 64'h0 || err64 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset64: out_valid=%b in_ready=%b imm=%h tgt=%h err=%b, expected 0 1 0 0 0",
               out_valid64, in_ready64, immext64, tgt64, err64);
    end
    tick();
  endtask

  task automatic test_formats();
    logic [31:0] t_instr[4] = '{32'hFFF00093, 32'hFE20AE23, 32'h123450B7, 32'h0010006F};
    logic [2:0]  t_src[4]   = '{3'd0, 3'd1, 3'd4, 3'd3};
    logic [31:0] t_pc[4]    = '{32'h100, 32'h200, 32'h0, 32'h1000};
    logic [31:0] t_imm[4]   = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
    logic [31:0] t_tgt[4]   = '{32'h000000FF, 32'h000001FC, 32'h12345000, 32'h00001800};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instr = t_instr[k]; immsrc = t_src[k]; pc = {32'h0, t_pc[k]}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid32 !== 1'b1 || immext32 !== t_imm[k] || tgt32 !== t_tgt[k] || err32 !== 1'b0) begin
        n_errors++;
        $display("FAIL format%0d: out_valid=%b imm=%h tgt=%h err=%b, expected 1 %h %h 0",
                 k, out_valid32, immext32, tgt32, err32, t_imm[k], t_tgt[k]);
      end
      tick();
    end
  endtask

  task automatic test_boundary();
    logic [31:0] t_instr[2] = '{32'hFE000CE3, 32'h0000A5A5};
    logic [2:0]  t_src[2]   = '{3'd2, 3'd7};
    logic [31:0] t_pc[2]    = '{32'h4, 32'h1234};
    logic [31:0] t_imm[2]   = '{32'hFFFFFFF8, 32'h0};
    logic [31:0] t_tgt[2]   = '{32'hFFFFFFFC, 32'h1234};
    logic        t_err[2]   = '{1'b0, 1'b1};
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      instr = t_instr[k]; immsrc = t_src[k]; pc = {32'h0, t_pc[k]}; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid32 !== 1'b1 || immext32 !== t_imm[k] || tgt32 !== t_tgt[k] || err32 !== t_err[k]) begin
        n_errors++;
        $display("FAIL boundary%0d: out_valid=%b imm=%h tgt=%h err=%b, expected 1 %h %h %b",
                 k, out_valid32, immext32, tgt32, err32, t_imm[k], t_tgt[k], t_err[k]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int  acc = 0;
    int  cyc = 0;
    int  pops0;
    bit  go;
    bit  need_new = 1'b1;
    bit  low_checked = 1'b0;
    pops0 = n_pops;
    flush = 1'b0;
    while (acc < 4 && cyc < 40) begin
      if (need_new) begin
        instr = $urandom; immsrc = 3'($urandom_range(0, 7)); pc = {$urandom, $urandom};
        need_new = 1'b0;
      end
      in_valid  = 1'b1;
      out_ready = (cyc >= 3);
      @(negedge clk);
      go = in_ready32;
      if (acc == 2 && !low_checked) begin
        low_checked = 1'b1;
        n_checks++;
        if (go !== 1'b0) begin
          n_errors++;
          $display("FAIL bp_in_ready: in_ready=%b after 2nd accept, expected 0", go);
        end
      end
      tick();
      cyc++;
      if (go) begin acc++; need_new = 1'b1; end
    end
    drain();
    n_checks++;
    if (n_pops - pops0 != 4) begin
      n_errors++;
      $display("FAIL bp_count: delivered %0d, expected 4", n_pops - pops0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      instr = $urandom; immsrc = 3'($urandom_range(0, 7)); pc = {$urandom, $urandom}; in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready32 !== 1'b1 || (k > 0 && out_valid32 !== 1'b1)) begin
        n_errors++;
        $display("FAIL stream%0d: in_ready=%b out_valid=%b, expected 1 1", k, in_ready32, out_valid32);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      instr = $urandom; immsrc = 3'($urandom_range(0, 6)); pc = {$urandom, $urandom}; in_valid = 1'b1;
      tick();
    end
    instr = 32'hFFF00093; immsrc = 3'd0; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
      n_errors++;
      $display("FAIL flush: out_valid=%b/%b in_ready=%b/%b, expected 0/0 1/1",
               out_valid32, out_valid64, in_ready32, in_ready64);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if (out_valid32 !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_drop%0d: out_valid=%b, expected 0", k, out_valid32);
      end
    end
    tick();
  endtask

  task automatic test_xlen64();
    logic [31:0] t_instr[3] = '{32'h800000B7, 32'h03F00013, 32'h000F8073};
    logic [2:0]  t_src[3]   = '{3'd4, 3'd6, 3'd5};
    logic [63:0] t_imm64[3] = '{64'hFFFFFFFF80000000, 64'h3F, 64'h1F};
    logic [31:0] t_imm32[3] = '{32'h80000000, 32'h1F, 32'h1F};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      instr = t_instr[k]; immsrc = t_src[k]; pc = 64'h0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (out_valid64 !== 1'b1 || immext64 !== t_imm64[k] || immext32 !== t_imm32[k]) begin
        n_errors++;
        $display("FAIL xlen64_%0d: out_valid=%b imm64=%h imm32=%h, expected 1 %h %h",
                 k, out_valid64, immext64, immext32, t_imm64[k], t_imm32[k]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit pending = 1'b0;
    repeat (300) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        instr = $urandom; immsrc = 3'($urandom_range(0, 7)); pc = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      pending = in_valid && (in_ready32 !== 1'b1) && !flush;
      tick();
    end
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_formats();
    test_boundary();
    test_backpressure();
    test_flush();
    test_xlen64();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
